bram_tap_sequencer: RTL and testbench
=====================================

# bram_tap_sequencer

Master-side controller for the beamformer sample buffer (the `BRAM` wrapper around the dual-port `DPRAM`). It accepts a stream of 4-bit samples, fills all eight buffer locations through the buffer's `load`/`write_addr`/`data_in` port, then reads the frame back through `start`/`read_addr`/`data_out`. Readout begins at a programmable tap offset and wraps around, which produces one delayed channel. The output is a framed sample stream for the summing stage.

## Interface
- `DATA_W`, 4, sample width; must equal the buffer data width
- `ADDR_W`, 3, buffer address width; DEPTH = 2**ADDR_W = 8
- `RD_LAT`, 2, cycles from a `start` pulse to valid `mem_q` for that read

- `clock`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input sample valid
- `in_data`  in  DATA_W  input sample
- `in_ready`  out  1  sequencer accepts `in_data` this cycle
- `go`  in  1  start readout (honoured only in FULL)
- `delay`  in  ADDR_W  tap offset, sampled when `go` is accepted
- `load`  out  1  to buffer `load`
- `start`  out  1  to buffer `start`
- `write_addr`  out  ADDR_W  to buffer `write_addr`
- `mem_wdata`  out  DATA_W  to buffer `data_in`
- `read_addr`  out  ADDR_W  to buffer `read_addr`
- `mem_q`  in  DATA_W  from buffer `data_out`
- `out_valid`  out  1  output sample valid; no backpressure
- `out_data`  out  DATA_W  output sample
- `out_last`  out  1  marks the 8th output sample of a frame
- `full`  out  1  high in FULL
- `busy`  out  1  high in READ or DRAIN

## Operation
- FSM states: IDLE, FILL, FULL, READ, DRAIN.
- IDLE: `in_ready`=1. The first handshake (`in_valid & in_ready`) writes sample 0 and moves to FILL.
- FILL: `in_ready`=1. Each handshake writes the next address: wr_cnt 0..7.
  - The 8th handshake (wr_cnt=7) moves to FULL, with `in_ready`=0 from the next cycle.
- Write alignment: the buffer registers `load` into its write enable.
  - `load` = the handshake, combinational, in cycle n.
  - `write_addr`/`mem_wdata` are registered from the handshake and presented in cycle n+1.
  - Result: data lands at the rising edge ending cycle n+1.
- FULL: `full`=1 and inputs are refused.
  - `go`=1 latches `delay` into base and moves to READ.
  - `go` in any other state is ignored.
- READ: runs 8 cycles with k = 0..7.
  - `start`=1.
  - `read_addr` is registered and equals (base + k) mod 8, i.e. ADDR_W-bit wrap, no saturation. It lags `start` by one cycle to match the buffer's registered read enable.
  - After k=7, move to DRAIN.
- DRAIN: wait until the last read's data has emitted, then return to IDLE. No extra idle cycle is required.
- Output: a RD_LAT-deep valid/last shift pipeline fed by `start`; `out_data` = `mem_q` when the pipeline tail is valid, otherwise held at 0.
- Back-to-back frames: the next frame's input is accepted from IDLE only. No fill overlaps a readout.
- Reset mid-operation: state returns to IDLE, counters clear, the in-flight pipeline is flushed, and no partial `out_last` is produced.

## Timing
- Reset values: `in_ready`=0 while `rst` is high and 1 after release (IDLE). All other outputs are 0: `load`, `start`, `write_addr`, `mem_wdata`, `read_addr`, `out_valid`, `out_data`, `out_last`, `full`, `busy`.
- Fill throughput: 1 sample/cycle. The minimum fill takes 8 cycles.
- Readout latency: first `out_valid` appears RD_LAT cycles after the first `start`. The 8 outputs are contiguous.
- Readout length: go to `out_last` = 1 + 7 + RD_LAT cycles.
- `busy` is high from the cycle after `go` is accepted through the cycle `out_last` is high.

## Structure
- Shared package `bram_seq_pkg`: the state enum (IDLE/FILL/FULL/READ/DRAIN), DATA_W/ADDR_W defaults, DEPTH.
- One sub-module: `valid_delay_pipe` (parametrised RD_LAT shift register carrying valid+last).
- Counters and the address adder stay in the top.

## Test plan
- Fill samples 1..8, `go` with `delay`=0 -> outputs 1,2,…,8, with `out_last` on 8 exactly RD_LAT cycles after the 8th `start`.
- Fill 1..8, `delay`=5 -> `read_addr` sequence 5,6,7,0,1,2,3,4 and outputs 6,7,8,1,2,3,4,5.
- Fill with `in_valid` gaps (1 high, 2 low, repeating) -> writes only on handshakes, addresses 0..7 in order, `full` after the 8th.
- `go` pulsed during IDLE/FILL/READ -> ignored, with no `start` and no state change; the 9th `in_valid` while FULL -> `in_ready`=0 and no `load`.
- Assert `rst` during the 4th readout cycle -> all outputs 0 immediately, no further `out_valid`/`out_last`; a refill of 8 and `go` then succeed normally.
- Two consecutive frames with `delay`=7 then `delay`=2 -> both frames correct, with no stale data from frame 1 in frame 2.

Source files
------------

// File: rtl/bram_seq_pkg.sv
// bram_seq_pkg: shared state encoding and default geometry for the
// beamformer buffer sequencer.
package bram_seq_pkg;
   typedef enum logic [2:0] {IDLE, FILL, FULL, READ, DRAIN} state_t;
   localparam int DEF_DATA_W = 4;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_RD_LAT = 2;
   localparam int DEPTH = 2 ** DEF_ADDR_W;
endpackage

// File: rtl/valid_delay_pipe.sv
// valid_delay_pipe: LAT-stage shift register carrying a valid/last pair
// alongside the buffer's read latency.
module valid_delay_pipe #(
   parameter int LAT = 2
) (
   input  logic clock,
   input  logic rst,
   input  logic in_valid,
   input  logic in_last,
   output logic out_valid,
   output logic out_last
);
   logic [LAT-1:0] v, l;
   always_ff @(posedge clock or posedge rst)
      if (rst) begin
         v <= '0;
         l <= '0;
      end else begin
         v[0] <= in_valid;
         l[0] <= in_last;
         for (int i = 1; i < LAT; i++) begin
            v[i] <= v[i-1];
            l[i] <= l[i-1];
         end
      end
   assign out_valid = v[LAT-1];
   assign out_last  = l[LAT-1];
endmodule

// File: rtl/bram_tap_sequencer.sv
// bram_tap_sequencer: fills the 8-entry sample buffer, then reads it back
// starting at a tap offset with wrap-around to form one delayed channel.
module bram_tap_sequencer
   import bram_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              go,
   input  logic [ADDR_W-1:0] delay,
   output logic              load,
   output logic              start,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [DATA_W-1:0] mem_q,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              full,
   output logic              busy
);
   state_t state;
   logic [ADDR_W-1:0] wr_cnt, k, base;
   logic take, tail_valid;
   // ready is gated by rst so nothing is accepted while reset is held
   assign in_ready = ~rst & (state == IDLE | state == FILL);
   assign take     = in_valid & in_ready;
   assign load     = take;
   assign start    = state == READ;
   assign full     = state == FULL;
   assign busy     = state == READ | state == DRAIN;
   assign out_valid = tail_valid;
   assign out_data  = tail_valid ? mem_q : '0;
   always_ff @(posedge clock or posedge rst)
      if (rst) begin
         state      <= IDLE;
         wr_cnt     <= '0;
         k          <= '0;
         base       <= '0;
         write_addr <= '0;
         mem_wdata  <= '0;
         read_addr  <= '0;
      end else begin
         // buffer registers load, so address/data follow one cycle later
         if (take) begin
            write_addr <= wr_cnt;
            mem_wdata  <= in_data;
         end
         case (state)
            IDLE, FILL: if (take) begin
               wr_cnt <= wr_cnt + ADDR_W'(1);
               state  <= wr_cnt == '1 ? FULL : FILL;
            end
            FULL: if (go) begin
               base  <= delay;
               k     <= '0;
               state <= READ;
            end
            READ: begin
               read_addr <= base + k;
               k         <= k + ADDR_W'(1);
               if (k == '1) state <= DRAIN;
            end
            DRAIN: if (out_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   valid_delay_pipe #(.LAT(RD_LAT)) pipe (
      .clock     (clock),
      .rst       (rst),
      .in_valid  (start),
      .in_last   (start & (k == '1)),
      .out_valid (tail_valid),
      .out_last  (out_last)
   );
endmodule

// File: tb/tb_bram_tap_sequencer.sv
// tb_bram_tap_sequencer: drives random frames through the sequencer and a
// behavioural buffer, checking every output against the expected tap stream.
module tb_bram_tap_sequencer;
   localparam int DW = 4, AW = 3, LAT = 2;
   logic clock = 0, rst = 1, in_valid = 0, go = 0;
   logic [DW-1:0] in_data = '0;
   logic [AW-1:0] delay = '0;
   logic in_ready, load, start, out_valid, out_last, full, busy;
   logic [AW-1:0] write_addr, read_addr;
   logic [DW-1:0] mem_wdata, out_data;
   logic [DW-1:0] mem_q = '0;
   logic we_q = 0, re_q = 0;
   logic [DW-1:0] ram [8];
   logic [DW-1:0] frame [8];
   int vectors = 0, miscompares = 0;

   always #5 clock = ~clock;

   // buffer model: registered write enable and registered read enable
   always @(posedge clock) begin
      we_q <= load;
      re_q <= start;
      if (we_q) ram[write_addr] <= mem_wdata;
      if (re_q) mem_q <= ram[read_addr];
   end

   bram_tap_sequencer dut (
      .clock(clock), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .go(go), .delay(delay), .load(load), .start(start),
      .write_addr(write_addr), .mem_wdata(mem_wdata), .read_addr(read_addr),
      .mem_q(mem_q), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .full(full), .busy(busy)
   );

   task automatic do_fill(input bit gaps);
      int n = 0, ph = 0, pend = -1;
      for (int cyc = 0; cyc < 64 && n < 8; cyc++) begin
         @(negedge clock);
         if (pend >= 0) begin
            vectors++;
            if ({write_addr, mem_wdata} !== {AW'(pend), frame[pend]}) begin
               miscompares++;
               $display("FAIL fill_write n=%0d got addr %0d data %h exp addr %0d data %h",
                        pend, write_addr, mem_wdata, pend, frame[pend]);
            end
         end
         in_valid = gaps ? (ph % 3 == 0) : 1'b1;
         ph++;
         in_data = in_valid ? frame[n] : DW'($urandom);
         go = 1'($urandom);
         delay = AW'($urandom);
         #1;
         vectors++;
         if ({in_ready, load, full, start, busy} !== {1'b1, in_valid, 3'b000}) begin
            miscompares++;
            $display("FAIL fill_ctrl n=%0d got %b exp %b", n,
                     {in_ready, load, full, start, busy}, {1'b1, in_valid, 3'b000});
         end
         pend = in_valid ? n : -1;
         if (in_valid) n++;
      end
      if (n < 8) begin
         miscompares++;
         $display("FAIL fill_timeout got %0d handshakes exp 8", n);
      end
      @(negedge clock);
      in_valid = 1;
      in_data = DW'($urandom);
      go = 0;
      #1;
      vectors++;
      if ({write_addr, mem_wdata} !== {AW'(7), frame[7]}) begin
         miscompares++;
         $display("FAIL fill_last_write got addr %0d data %h exp addr 7 data %h",
                  write_addr, mem_wdata, frame[7]);
      end
      vectors++;
      if ({in_ready, load, full, start, busy} !== 5'b00100) begin
         miscompares++;
         $display("FAIL full_refuse got %b exp 00100", {in_ready, load, full, start, busy});
      end
      @(negedge clock);
      in_valid = 0;
      #1;
      vectors++;
      if ({full, write_addr} !== {1'b1, AW'(7)}) begin
         miscompares++;
         $display("FAIL full_hold got full %b addr %0d exp full 1 addr 7", full, write_addr);
      end
   endtask

   task automatic do_read(input logic [AW-1:0] d);
      logic ev;
      logic [DW-1:0] exp_data;
      logic [9:0] got, want;
      @(negedge clock);
      go = 1;
      delay = d;
      #1;
      vectors++;
      if ({full, start, busy} !== 3'b100) begin
         miscompares++;
         $display("FAIL go_cycle got %b exp 100", {full, start, busy});
      end
      for (int t = 1; t <= 9 + LAT; t++) begin
         @(negedge clock);
         go = (t < 9 + LAT) ? 1'($urandom) : 1'b0;
         delay = AW'($urandom);
         in_valid = (t < 9 + LAT) ? 1'($urandom) : 1'b0;
         in_data = DW'($urandom);
         #1;
         ev = t >= 1 + LAT && t <= 8 + LAT;
         exp_data = ev ? frame[(int'(d) + t + 7 - LAT) % 8] : '0;
         got  = {start, busy, in_ready, load, out_valid, out_last, out_data};
         want = {t <= 8, t <= 8 + LAT, t == 9 + LAT, 1'b0, ev, t == 8 + LAT, exp_data};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL read d=%0d t=%0d got %b exp %b", d, t, got, want);
         end
         if (t >= 2 && t <= 9) begin
            vectors++;
            if (read_addr !== AW'(int'(d) + t - 2)) begin
               miscompares++;
               $display("FAIL read_addr d=%0d t=%0d got %0d exp %0d", d, t, read_addr,
                        AW'(int'(d) + t - 2));
            end
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clock);
      in_valid = 1;
      go = 1;
      #1;
      vectors++;
      if ({in_ready, load, start, write_addr, mem_wdata, read_addr, out_valid, out_data,
           out_last, full, busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold got nonzero outputs ready %b load %b start %b",
                  in_ready, load, start);
      end
      in_valid = 0;
      go = 0;
      rst = 0;
      #1;
      vectors++;
      if ({in_ready, load, full, start, busy} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_release got %b exp 10000", {in_ready, load, full, start, busy});
      end
   endtask

   task automatic test_basic;
      for (int i = 0; i < 8; i++) frame[i] = DW'(i + 1);
      do_fill(0);
      do_read(0);
   endtask

   task automatic test_delay5;
      for (int i = 0; i < 8; i++) frame[i] = DW'(i + 1);
      do_fill(0);
      do_read(5);
   endtask

   task automatic test_gaps;
      for (int i = 0; i < 8; i++) frame[i] = DW'($urandom);
      do_fill(1);
      do_read(AW'($urandom));
   endtask

   task automatic test_go_ignored;
      @(negedge clock);
      go = 1;
      #1;
      vectors++;
      if (start !== 1'b0) begin
         miscompares++;
         $display("FAIL go_idle_start got %b exp 0", start);
      end
      @(negedge clock);
      go = 0;
      #1;
      vectors++;
      if ({in_ready, full, start, busy} !== 4'b1000) begin
         miscompares++;
         $display("FAIL go_idle_state got %b exp 1000", {in_ready, full, start, busy});
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++) frame[i] = DW'($urandom);
         do_fill(1'($urandom));
         do_read(AW'($urandom));
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 8; i++) frame[i] = DW'($urandom);
      do_fill(0);
      @(negedge clock);
      go = 1;
      delay = AW'($urandom);
      for (int t = 1; t <= 4; t++) begin
         @(negedge clock);
         go = 0;
      end
      rst = 1;
      in_valid = 1;
      #1;
      vectors++;
      if ({in_ready, load, start, write_addr, mem_wdata, read_addr, out_valid, out_data,
           out_last, full, busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid got start %b busy %b addr %0d valid %b",
                  start, busy, write_addr, out_valid);
      end
      @(negedge clock);
      rst = 0;
      in_valid = 0;
      for (int t = 0; t < 12; t++) begin
         @(negedge clock);
         #1;
         vectors++;
         if ({in_ready, out_valid, out_last, start, busy, full} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_flush t=%0d got %b exp 100000", t,
                     {in_ready, out_valid, out_last, start, busy, full});
         end
      end
      for (int i = 0; i < 8; i++) frame[i] = DW'($urandom);
      do_fill(0);
      do_read(AW'($urandom));
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) frame[i] = DW'($urandom);
      do_fill(0);
      do_read(7);
      for (int i = 0; i < 8; i++) frame[i] = ~frame[i];
      do_fill(0);
      do_read(2);
   endtask

   initial begin
      #200000;
      miscompares++;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_basic;
      test_delay5;
      test_gaps;
      test_go_ignored;
      test_random;
      test_reset_mid;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
